// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM for the multicycle RV32I datapath
module multicycle_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state;
    logic   retire;

    // Retirement coincides with every transition back into FETCH.
    always_comb begin
        retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                 ((state == MEMWRITE) && mem_ready);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_R:              state <= EXECUTER;
                        OP_I:              state <= EXECUTEI;
                        OP_BR:             state <= BEQ;
                        OP_JAL:            state <= JAL;
                        default:           state <= TRAP;
                    endcase
                end
                MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
                TRAP:     state <= TRAP;
                default:  state <= TRAP;
            endcase
        end
    end

    logic pc_update_raw, branch_raw, ir_write_raw, reg_write_raw, mem_write_raw;

    always_comb begin
        pc_update_raw = 1'b0;
        branch_raw    = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ALUOp         = 2'b00;
        illegal       = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB       = 2'b10;
                ResultSrc     = 2'b10;
                ir_write_raw  = mem_ready;
                pc_update_raw = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB:    reg_write_raw = 1'b1;
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                branch_raw = 1'b1;
            end
            JAL: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b10;
                pc_update_raw = 1'b1;
            end
            TRAP:     illegal = 1'b1;
            default:  illegal = 1'b1;
        endcase
    end

    // Write enables are squashed combinationally while reset is held.
    always_comb begin
        PCUpdate = pc_update_raw & reset_n;
        Branch   = branch_raw    & reset_n;
        IRWrite  = ir_write_raw  & reset_n;
        RegWrite = reg_write_raw & reset_n;
        MemWrite = mem_write_raw & reset_n;
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_I: ImmSrc = 2'b00;
            OP_STORE:      ImmSrc = 2'b01;
            OP_BR:         ImmSrc = 2'b10;
            OP_JAL:        ImmSrc = 2'b11;
            default:       ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - scoreboard bench for multicycle_main_fsm
module tb_multicycle_main_fsm;

    localparam int CNT_W = 3;
    localparam int VW    = 17 + CNT_W;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] LW_OP  = 7'b0000011;
    localparam logic [6:0] SW_OP  = 7'b0100011;
    localparam logic [6:0] BEQ_OP = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] ILL_OP = 7'b0110111;

    typedef enum int {
        T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB, T_BEQ, T_JAL, T_TRAP
    } tst_t;

    typedef struct {
        string          name;
        logic [VW-1:0]  exp;
    } item_t;

    logic             clk;
    logic             reset_n;
    logic [6:0]       op;
    logic             mem_ready;
    logic             PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    bit    done   = 0;

    multicycle_main_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .instret(instret)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] exp_out(input tst_t s, input bit mr, input bit rn,
                                             input logic [6:0] o, input int ret);
        logic pcu, br, irw, rw, mw, adr, ill;
        logic [1:0] sa, sbv, res, aop, imm;
        logic [CNT_W-1:0] cnt;
        {pcu, br, irw, rw, mw, adr, ill} = '0;
        {sa, sbv, res, aop} = '0;
        case (s)
            T_F:    begin sbv = 2'b10; res = 2'b10; irw = mr; pcu = mr; end
            T_D:    begin sa = 2'b01; sbv = 2'b01; end
            T_MA:   begin sa = 2'b10; sbv = 2'b01; end
            T_MR:   adr = 1;
            T_MWB:  begin res = 2'b01; rw = 1; end
            T_MW:   begin adr = 1; mw = 1; end
            T_ER:   begin sa = 2'b10; aop = 2'b10; end
            T_EI:   begin sa = 2'b10; sbv = 2'b01; aop = 2'b10; end
            T_AWB:  rw = 1;
            T_BEQ:  begin sa = 2'b10; aop = 2'b01; br = 1; end
            T_JAL:  begin sa = 2'b01; sbv = 2'b10; pcu = 1; end
            default: ill = 1;
        endcase
        if (!rn) {pcu, br, irw, rw, mw} = '0;
        case (o)
            7'b0000011, 7'b0010011: imm = 2'b00;
            7'b0100011:             imm = 2'b01;
            7'b1100011:             imm = 2'b10;
            7'b1101111:             imm = 2'b11;
            default:                imm = 2'b00;
        endcase
        cnt = CNT_W'(ret);
        return {pcu, br, irw, rw, mw, adr, sa, sbv, res, aop, imm, ill, cnt};
    endfunction

    task automatic v(input string nm, input bit rn, input logic [6:0] o, input bit mr,
                     input tst_t s, input int ret);
        item_t it;
        reset_n   = rn;
        op        = o;
        mem_ready = mr;
        it.name   = nm;
        it.exp    = exp_out(s, mr, rn, o, ret);
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the presented outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            logic [VW-1:0] act;
            it  = sb.pop_front();
            act = {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ALUOp, ImmSrc, illegal, instret};
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        reset_n   = 0;
        op        = R_OP;
        mem_ready = 1;
        @(posedge clk);
        #1;
        v("reset0", 0, R_OP, 1, T_F, 0);
        v("reset1", 0, R_OP, 1, T_F, 0);
        // R-type add
        v("r_fetch", 1, R_OP, 1, T_F, 0);
        v("r_decode", 1, R_OP, 0, T_D, 0);
        v("r_exec", 1, R_OP, 0, T_ER, 0);
        v("r_wb", 1, R_OP, 1, T_AWB, 0);
        // lw with three MEMREAD wait cycles
        v("lw_fetch", 1, LW_OP, 1, T_F, 1);
        v("lw_decode", 1, LW_OP, 1, T_D, 1);
        v("lw_adr", 1, LW_OP, 0, T_MA, 1);
        v("lw_rd_w0", 1, LW_OP, 0, T_MR, 1);
        v("lw_rd_w1", 1, LW_OP, 0, T_MR, 1);
        v("lw_rd_w2", 1, LW_OP, 0, T_MR, 1);
        v("lw_rd", 1, LW_OP, 1, T_MR, 1);
        v("lw_wb", 1, LW_OP, 0, T_MWB, 1);
        // sw with FETCH stalled two cycles and one MEMWRITE wait
        v("sw_fetch_w0", 1, SW_OP, 0, T_F, 2);
        v("sw_fetch_w1", 1, SW_OP, 0, T_F, 2);
        v("sw_fetch", 1, SW_OP, 1, T_F, 2);
        v("sw_decode", 1, SW_OP, 1, T_D, 2);
        v("sw_adr", 1, SW_OP, 1, T_MA, 2);
        v("sw_wr_w0", 1, SW_OP, 0, T_MW, 2);
        v("sw_wr", 1, SW_OP, 1, T_MW, 2);
        // beq then jal
        v("beq_fetch", 1, BEQ_OP, 1, T_F, 3);
        v("beq_decode", 1, BEQ_OP, 1, T_D, 3);
        v("beq_exec", 1, BEQ_OP, 0, T_BEQ, 3);
        v("jal_fetch", 1, JAL_OP, 1, T_F, 4);
        v("jal_decode", 1, JAL_OP, 1, T_D, 4);
        v("jal_exec", 1, JAL_OP, 0, T_JAL, 4);
        v("jal_wb", 1, JAL_OP, 1, T_AWB, 4);
        // I-type immediate path
        v("i_fetch", 1, 7'b0010011, 1, T_F, 5);
        v("i_decode", 1, 7'b0010011, 1, T_D, 5);
        v("i_exec", 1, 7'b0010011, 1, T_EI, 5);
        v("i_wb", 1, 7'b0010011, 1, T_AWB, 5);
        // illegal opcode traps until reset
        v("ill_fetch", 1, ILL_OP, 1, T_F, 6);
        v("ill_decode", 1, ILL_OP, 1, T_D, 6);
        for (int i = 0; i < 10; i++)
            v("trap", 1, (i % 2 == 1) ? LW_OP : ILL_OP, bit'(i % 2), T_TRAP, 6);
        v("trap_rst", 0, ILL_OP, 1, T_TRAP, 6);
        v("trap_rst_f", 0, ILL_OP, 1, T_F, 0);
        // eight branches wrap the retire counter back to zero
        for (int k = 0; k < 8; k++) begin
            v("wrap_fetch", 1, BEQ_OP, 1, T_F, k);
            v("wrap_decode", 1, BEQ_OP, 1, T_D, k);
            v("wrap_beq", 1, BEQ_OP, 1, T_BEQ, k);
        end
        v("wrap_done", 1, R_OP, 0, T_F, 8);
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle RV32I datapath.
- Sits directly upstream of the ALU decoder: produces ALUOp (2b) plus all datapath mux selects and write enables, sequenced one state per clock.
- Stalls on a memory ready handshake.
- Traps on unsupported opcodes.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- op  in  7  instruction opcode field from the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCUpdate  out  1  PC write enable (unconditional).
- Branch  out  1  conditional PC write; datapath qualifies with the compare flag.
- IRWrite  out  1  instruction register / OldPC write enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write request.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = register A.
- ALUSrcB  out  2  00 = register B, 01 = ImmExt, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = read Data, 10 = ALUResult.
- ALUOp  out  2  to ALU decoder: 00 = add, 01 = subtract, 10 = decode funct fields.
- ImmSrc  out  2  combinational from op: 00 = I, 01 = S, 10 = B, 11 = J; 00 for other opcodes.
- illegal  out  1  sticky; high while in TRAP.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State register updates on rising clk only.
- reset_n low at an edge forces state FETCH and instret 0, regardless of current state; this includes a stalled memory access or TRAP.
- While reset_n is low, PCUpdate, Branch, IRWrite, RegWrite and MemWrite are forced to 0. All other outputs are Moore-decoded from state.
- Any field not listed for a state is 0.
- State outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready (the only Mealy outputs). Stay while mem_ready=0, else go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Stay until mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH; retire.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready. On mem_ready go to FETCH; retire.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH; retire.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH; retire.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB (retire counted there).
  - TRAP: all enables 0, illegal=1. Terminal until reset; op and mem_ready are ignored.
- "Retire" means instret increments by 1 on the same edge as the transition into FETCH. It wraps from 2^CNT_W-1 to 0.
- Latency with mem_ready tied high:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
- Each wait cycle with mem_ready=0 adds exactly one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready is ignored in all other states.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles while op=0110011 and mem_ready=1. Required: all enables 0, instret=0. First cycle after release is FETCH with IRWrite=PCUpdate=1.
- R-type add, mem_ready=1: state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUOp=10 in EXECUTER; RegWrite=1 only in ALUWB; instret 0 -> 1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEMREAD: AdrSrc=1 for 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1. Total 8 cycles; instret +1.
- sw with FETCH stalled 2 cycles: IRWrite stays 0 until mem_ready=1. MemWrite=1 exactly in the MEMWRITE cycles; RegWrite never 1.
- beq then jal: BEQ state shows ALUOp=01, Branch=1. JAL shows PCUpdate=1, ALUSrcA=01, ALUSrcB=10, followed by ALUWB. instret +2.
- Illegal op=0110111: DECODE -> TRAP; illegal=1 and all enables 0 for 10 cycles. Asserting reset_n=0 mid-trap returns to FETCH with illegal=0 and instret=0.
